// File: rtl/vga_timing_gen_if.sv
// VGA timing bus: pixel-advance enable in, sync/position/markers out.
// Optional frame_cnt member exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    logic       en;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    modport master (input en, output hsync, vsync, display_on, hpos, vpos,
                    line_start, frame_start, frame_cnt);
    modport slave  (output en, input hsync, vsync, display_on, hpos, vpos,
                    line_start, frame_start, frame_cnt);
`else
    modport master (input en, output hsync, vsync, display_on, hpos, vpos,
                    line_start, frame_start);
    modport slave  (output en, input hsync, vsync, display_on, hpos, vpos,
                    line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync and markers.
// Define VGA_FRAME_COUNT_EN to add a 16-bit wrapping frame counter (frame_cnt).
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int unsigned POS_W    = 10;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [POS_W-1:0] hpos_q, vpos_q;
    logic [POS_W-1:0] h_nxt_c, v_nxt_c;
    logic             h_wrap_c;
    logic             hs_c, vs_c, de_c, ls_c, fs_c;
    logic             hsync_q, vsync_q, de_q, ls_q, fs_q;

    // Next raster position; outputs are decoded from it so they land with the counters.
    always_comb begin
        h_wrap_c = (hpos_q >= POS_W'(H_TOTAL - 1));
        h_nxt_c  = h_wrap_c ? '0 : hpos_q + POS_W'(1);
        v_nxt_c  = vpos_q;
        if (h_wrap_c) begin
            v_nxt_c = (vpos_q >= POS_W'(V_TOTAL - 1)) ? '0 : vpos_q + POS_W'(1);
        end
        hs_c = (h_nxt_c >= POS_W'(HS_START)) && (h_nxt_c <= POS_W'(HS_END));
        vs_c = (v_nxt_c >= POS_W'(VS_START)) && (v_nxt_c <= POS_W'(VS_END));
        de_c = (h_nxt_c < POS_W'(H_DISPLAY)) && (v_nxt_c < POS_W'(V_DISPLAY));
        ls_c = (h_nxt_c == '0);
        fs_c = ls_c && (v_nxt_c == '0);
    end

    // Reset parks at the last pixel so the first enabled edge opens frame 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q  <= POS_W'(H_TOTAL - 1);
            vpos_q  <= POS_W'(V_TOTAL - 1);
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (vga.en) begin
            hpos_q  <= h_nxt_c;
            vpos_q  <= v_nxt_c;
            hsync_q <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q <= vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de_q    <= de_c;
            ls_q    <= ls_c;
            fs_q    <= fs_c;
        end
    end

    assign vga.hpos        = hpos_q;
    assign vga.vpos        = vpos_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.display_on  = de_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    // Counts edges that open a new frame; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (vga.en && fs_c) begin
            frame_cnt_q <= frame_cnt_q + 16'(1);
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster and a linear-index model.
// Define VGA_FRAME_COUNT_EN to also exercise the frame counter.
module tb_vga_timing_gen;
    localparam int HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int VD = 12, VF = 2, VS = 3, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int HS0 = HD + HF, HS1 = HD + HF + HS - 1;
    localparam int VS0 = VD + VF, VS1 = VD + VF + VS - 1;
    localparam logic SA = 1'b0;

    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;

    // Model: raster position as a single pixel index within the frame.
    int          p;
    logic [9:0]  m_h, m_v;
    logic        m_hs, m_vs, m_de, m_ls, m_fs;
    logic [15:0] m_fc;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(SA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void derive();
        int h, v;
        h    = p % HT;
        v    = p / HT;
        m_h  = 10'(h);
        m_v  = 10'(v);
        m_hs = (h >= HS0 && h <= HS1) ? SA : ~SA;
        m_vs = (v >= VS0 && v <= VS1) ? SA : ~SA;
        m_de = (h < HD) && (v < VD);
        m_ls = (h == 0);
        m_fs = (h == 0) && (v == 0);
    endfunction

    function automatic void model_reset();
        p    = FT - 1;
        m_fc = '0;
        derive();
    endfunction

    task automatic tick(input logic e);
        vif.en = e;
        @(posedge clk);
        if (e) begin
            p = (p + 1) % FT;
            if (p == 0) m_fc = m_fc + 16'(1);
        end
        derive();
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < FT + 2 && !(m_h == 10'(h) && m_v == 10'(v)); i++) tick(1'b1);
        n_cmp++;
        if (vif.hpos !== 10'(h) || vif.vpos !== 10'(v)) begin
            n_err++;
            $display("FAIL run_to: got %0d,%0d want %0d,%0d", vif.hpos, vif.vpos, h, v);
        end
    endtask

    task automatic apply_reset();
        vif.en = 1'b0;
        reset  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start}
            !== {10'(HT - 1), 10'(VT - 1), ~SA, ~SA, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start);
        end
        tick(1'b1);
        n_cmp++;
        if ({vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start}
            !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL first_edge: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start);
        end
    endtask

    task automatic test_line();
        int hs_cnt, first_hs;
        hs_cnt   = 0;
        first_hs = -1;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1);
            if (vif.hsync === SA) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(vif.hpos);
            end
        end
        n_cmp++;
        if (hs_cnt != HS) begin
            n_err++;
            $display("FAIL line_hsync_len: got %0d want %0d", hs_cnt, HS);
        end
        n_cmp++;
        if (first_hs != HS0) begin
            n_err++;
            $display("FAIL line_hsync_start: got %0d want %0d", first_hs, HS0);
        end
        run_to(HT - 1, 4);
        tick(1'b1);
        n_cmp++;
        if ({vif.hpos, vif.vpos, vif.line_start, vif.frame_start} !== {10'd0, 10'd5, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL line_wrap: got h=%0d v=%0d ls=%b fs=%b want 0,5,1,0",
                     vif.hpos, vif.vpos, vif.line_start, vif.frame_start);
        end
    endtask

    task automatic test_frame();
        int n, vs_cnt, de_cnt;
        bit seen;
        seen = 0;
        for (int i = 0; i < FT + 2 && !seen; i++) begin
            tick(1'b1);
            seen = (vif.frame_start === 1'b1);
        end
        n = 0; vs_cnt = 0; de_cnt = 0; seen = 0;
        for (int i = 0; i < 2 * FT && !seen; i++) begin
            tick(1'b1);
            n++;
            if (vif.vsync === SA) vs_cnt++;
            if (vif.display_on === 1'b1) de_cnt++;
            seen = (vif.frame_start === 1'b1);
        end
        n_cmp++;
        if (n != FT) begin
            n_err++;
            $display("FAIL frame_period: got %0d want %0d", n, FT);
        end
        n_cmp++;
        if (vs_cnt != VS * HT) begin
            n_err++;
            $display("FAIL frame_vsync_len: got %0d want %0d", vs_cnt, VS * HT);
        end
        n_cmp++;
        if (de_cnt != HD * VD) begin
            n_err++;
            $display("FAIL frame_display_cnt: got %0d want %0d", de_cnt, HD * VD);
        end
    endtask

    task automatic test_en_hold();
        run_to(HS0 - 1, 3);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            n_cmp++;
            if ({vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start}
                !== {m_h, m_v, m_hs, m_vs, m_de, m_ls, m_fs} || vif.hsync !== ~SA) begin
                n_err++;
                $display("FAIL en_hold: got h=%0d hs=%b want h=%0d hs=%b", vif.hpos, vif.hsync, m_h, ~SA);
            end
        end
        tick(1'b1);
        n_cmp++;
        if (vif.hsync !== SA || vif.hpos !== 10'(HS0)) begin
            n_err++;
            $display("FAIL en_resume: got h=%0d hs=%b want h=%0d hs=%b", vif.hpos, vif.hsync, HS0, SA);
        end
    endtask

    task automatic test_random();
        logic [26:0] got, exp;
        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom_range(0, 3) != 0));
            got = {vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start};
            exp = {m_h, m_v, m_hs, m_vs, m_de, m_ls, m_fs};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        run_to(HS0 + 2, VS0 + 1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start}
            !== {10'(HT - 1), 10'(VT - 1), ~SA, ~SA, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midframe_reset: got h=%0d v=%0d hs=%b vs=%b", vif.hpos, vif.vpos, vif.hsync, vif.vsync);
        end
        vif.en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tick(1'b1);
        n_cmp++;
        if ({vif.hpos, vif.vpos, vif.display_on, vif.line_start, vif.frame_start}
            !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL midframe_restart: got h=%0d v=%0d de=%b ls=%b fs=%b",
                     vif.hpos, vif.vpos, vif.display_on, vif.line_start, vif.frame_start);
        end
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_cnt();
        apply_reset();
        for (int i = 0; i < 3 * FT; i++) tick(1'b1);
        n_cmp++;
        if (vif.frame_cnt !== 16'd3 || vif.frame_cnt !== m_fc) begin
            n_err++;
            $display("FAIL frame_cnt_3: got %0d want 3", vif.frame_cnt);
        end
        vif.en = 1'b0;
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        m_fc = 16'hFFFF;
        run_to(0, 0);
        n_cmp++;
        if (vif.frame_cnt !== 16'd0 || m_fc !== 16'd0) begin
            n_err++;
            $display("FAIL frame_cnt_wrap: got %0d want 0", vif.frame_cnt);
        end
    endtask
`endif

    initial begin
        reset  = 1'b0;
        vif.en = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_line();
        test_frame();
        test_en_hold();
        test_random();
        test_reset_midframe();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_ACTIVE, default 0, the active level of hsync and vsync.
REQ-006 clk  input  1  pixel clock, 25 MHz nominal; all state on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 en  input  1  pixel advance enable; when low all state holds.
REQ-009 hsync  output  1  horizontal sync at SYNC_ACTIVE level during the sync window.
REQ-010 vsync  output  1  vertical sync at SYNC_ACTIVE level during the sync window.
REQ-011 display_on  output  1  high when the current position is visible.
REQ-012 hpos  output  10  current pixel column.
REQ-013 vpos  output  10  current line.
REQ-014 line_start  output  1  high when hpos==0.
REQ-015 frame_start  output  1  high when hpos==0 and vpos==0.

Function
REQ-016 SHALL define H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL=V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-017 SHALL count hpos from 0 to H_TOTAL-1 by 1 on each clk edge with en=1, then wrap to 0.
REQ-018 SHALL increment vpos only on the edge where hpos wraps, and SHALL wrap vpos from V_TOTAL-1 to 0 on that same edge.
REQ-019 SHALL assert hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), otherwise inactive.
REQ-020 SHALL assert vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), otherwise inactive.
REQ-021 SHALL assert display_on exactly when hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-022 SHALL drive hsync, vsync, display_on, line_start and frame_start from flip-flops, not combinational decode, and keep them cycle-aligned with hpos/vpos (zero skew).
REQ-023 SHALL hold all outputs unchanged while en=0; line_start and frame_start hold their level and do not re-pulse.
REQ-024 SHALL never output hpos>=H_TOTAL or vpos>=V_TOTAL.

Reset
REQ-025 SHALL on reset set hpos=H_TOTAL-1, vpos=V_TOTAL-1, display_on=0, line_start=0, frame_start=0, hsync=vsync=~SYNC_ACTIVE.
REQ-026 SHALL produce hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1 on the first en=1 edge after reset release.
REQ-027 SHALL take reset mid-frame immediately, with no partial-line completion.

Configuration
REQ-028 With macro VGA_FRAME_COUNT_EN defined, SHALL add output frame_cnt[15:0].
REQ-029 frame_cnt SHALL reset to 0, increment by 1 on each edge where frame_start becomes 1, and wrap from 65535 to 0.
REQ-030 Without VGA_FRAME_COUNT_EN, the port and its counter SHALL be absent.

Verification
REQ-031 Reset, then en=1 for one clk -> hpos=0, vpos=0, display_on=1, frame_start=1, hsync=vsync=1.
REQ-032 Run one line -> hsync low exactly at hpos 656..751 (96 cycles); hpos 799 -> next edge hpos=0, vpos+1, line_start=1.
REQ-033 Run one full frame -> 420000 cycles between frame_start pulses; vsync low for lines 490..491 (1600 cycles); display_on high for 307200 cycles.
REQ-034 Toggle en low for 5 cycles at hpos=655 -> all outputs frozen; hsync asserts on the first enabled edge after en returns high.
REQ-035 Assert reset at hpos=700, vpos=491 -> outputs immediately at REQ-025 values; frame restarts per REQ-026.
REQ-036 With VGA_FRAME_COUNT_EN, run 3 frames -> frame_cnt=3; preload frame_cnt=65535 via force -> next frame_cnt=0.
